if_id_fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Owns the PC, issues instruction-memory reads and accepts branch redirects from the MEM stage.
- Holds on hazard stalls and registers PC+4 and the instruction for the decode stage.
- Decode stage consumes o_PCplus4/o_Instr/o_Valid and forwards PC+4 into the ID/EX register.

---
 rtl/if_id_fetch_stage_pkg.sv | 25 ++
 rtl/if_id_fetch_stage_if.sv | 34 +++
 rtl/if_id_fetch_stage_pc_register.sv | 39 +++
 rtl/if_id_fetch_stage.sv | 112 +++++++++++
 tb/tb_if_id_fetch_stage.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/if_id_fetch_stage_pkg.sv
// ============================================================================
// if_id_fetch_stage_pkg : shared fetch-stage constants, FSM states, helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package if_id_fetch_stage_pkg;

   localparam int          XLEN        = 32;
   localparam logic [31:0] c_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
   localparam logic [31:0] c_PC_STEP   = 32'd4;

   typedef enum logic [0:0] {
      ST_FETCH = 1'b0,
      ST_WAIT  = 1'b1
   } fetch_state_e;

   function automatic logic [XLEN-1:0] align_addr(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_fetch_stage_if.sv
// ============================================================================
// if_id_fetch_stage_if : hazard/branch control, imem bus and IF/ID outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface if_id_fetch_stage_if;
   import if_id_fetch_stage_pkg::*;

   logic            i_stall;
   logic            i_PCSrc;
   logic [XLEN-1:0] i_BranchTarget;
   logic            i_imem_ready;
   logic [XLEN-1:0] i_imem_rdata;
   logic [XLEN-1:0] o_imem_addr;
   logic            o_imem_req;
   logic [XLEN-1:0] o_PC;
   logic [XLEN-1:0] o_PCplus4;
   logic [XLEN-1:0] o_Instr;
   logic            o_Valid;

   modport master (
      input  i_stall, i_PCSrc, i_BranchTarget, i_imem_ready, i_imem_rdata,
      output o_imem_addr, o_imem_req, o_PC, o_PCplus4, o_Instr, o_Valid
   );

   modport slave (
      output i_stall, i_PCSrc, i_BranchTarget, i_imem_ready, i_imem_rdata,
      input  o_imem_addr, o_imem_req, o_PC, o_PCplus4, o_Instr, o_Valid
   );

endinterface

`default_nettype wire

// File: rtl/if_id_fetch_stage_pc_register.sv
// ============================================================================
// if_id_fetch_stage_pc_register : PC flop with redirect mux and +4 adder
// Rev 1.0
// ============================================================================
`default_nettype none

module if_id_fetch_stage_pc_register
   import if_id_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = c_RESET_PC
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_load_en,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_target,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_pc_plus4
);

   logic [XLEN-1:0] r_pc;

   // Modulo-2^32 add: 32'hFFFF_FFFC wraps to zero.
   assign o_pc_plus4 = r_pc + c_PC_STEP;
   assign o_pc       = r_pc;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_pc <= align_addr(RESET_PC);
      end else if (i_redirect) begin
         r_pc <= align_addr(i_target);
      end else if (i_load_en) begin
         r_pc <= o_pc_plus4;
      end
   end

endmodule

`default_nettype wire

// File: rtl/if_id_fetch_stage.sv
// ============================================================================
// if_id_fetch_stage : MIPS IF stage + IF/ID register; optional FETCH_PERF_CNT_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module if_id_fetch_stage
   import if_id_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = c_RESET_PC,
   parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   if_id_fetch_stage_if.master  bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]          o_FetchCnt,
   output logic [31:0]          o_BubbleCnt
`endif
);

   logic [XLEN-1:0] w_pc;
   logic [XLEN-1:0] w_pc_plus4;
   logic            w_load_normal;
   logic            w_load_bubble;
   logic [XLEN-1:0] r_pcplus4;
   logic [XLEN-1:0] r_instr;
   logic            r_valid;
   fetch_state_e    r_state;
   fetch_state_e    w_state_next;

   // A flush overrides both a stall and an imem miss.
   assign w_load_normal = !bus.i_PCSrc && !bus.i_stall && bus.i_imem_ready;
   assign w_load_bubble = bus.i_PCSrc || (!bus.i_stall && !bus.i_imem_ready);

   if_id_fetch_stage_pc_register #(
      .RESET_PC   (RESET_PC)
   ) u_pc_register (
      .i_clk      (i_clk),
      .i_rstn     (i_rstn),
      .i_load_en  (w_load_normal),
      .i_redirect (bus.i_PCSrc),
      .i_target   (bus.i_BranchTarget),
      .o_pc       (w_pc),
      .o_pc_plus4 (w_pc_plus4)
   );

   assign bus.o_imem_addr = w_pc;
   assign bus.o_imem_req  = i_rstn;
   assign bus.o_PC        = w_pc;
   assign bus.o_PCplus4   = r_pcplus4;
   assign bus.o_Instr     = r_instr;
   assign bus.o_Valid     = r_valid;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_pcplus4 <= '0;
         r_instr   <= NOP_INSTR;
         r_valid   <= 1'b0;
      end else if (w_load_bubble) begin
         r_pcplus4 <= '0;
         r_instr   <= NOP_INSTR;
         r_valid   <= 1'b0;
      end else if (w_load_normal) begin
         r_pcplus4 <= w_pc_plus4;
         r_instr   <= bus.i_imem_rdata;
         r_valid   <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   // After a redirect the new address is re-evaluated in FETCH next cycle.
   always_comb begin
      w_state_next = r_state;
      if (bus.i_PCSrc) begin
         w_state_next = ST_FETCH;
      end else if (!bus.i_stall) begin
         w_state_next = bus.i_imem_ready ? ST_FETCH : ST_WAIT;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_bubble_cnt;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_fetch_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (w_load_normal) r_fetch_cnt  <= r_fetch_cnt + 32'd1;
         if (w_load_bubble) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
   end

   assign o_FetchCnt  = r_fetch_cnt;
   assign o_BubbleCnt = r_bubble_cnt;
`else
   // Counters absent in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_fetch_stage.sv
// ============================================================================
// tb_if_id_fetch_stage : vector table, reset sequences and random vs. model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_id_fetch_stage;

   logic clk;
   logic rstn;
   int   n_tests;
   int   n_fail;

   if_id_fetch_stage_if bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] bubble_cnt;
`endif

   if_id_fetch_stage dut (
      .i_clk       (clk),
      .i_rstn      (rstn),
      .bus         (bus)
`ifdef FETCH_PERF_CNT_EN
      ,
      .o_FetchCnt  (fetch_cnt),
      .o_BubbleCnt (bubble_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] m_pc, m_p4, m_instr;
   logic        m_valid;
   logic [31:0] m_fcnt, m_bcnt;

   typedef struct {
      logic        stall;
      logic        pcsrc;
      logic [31:0] target;
      logic        ready;
      logic [31:0] rdata;
      logic [31:0] e_pc;
      logic [31:0] e_p4;
      logic [31:0] e_instr;
      logic        e_valid;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_p4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      m_fcnt = 32'h0; m_bcnt = 32'h0;
   endtask

   task automatic check_model(input string tag);
      chk({tag, " PC"},      bus.o_PC,      m_pc);
      chk({tag, " PCplus4"}, bus.o_PCplus4, m_p4);
      chk({tag, " Instr"},   bus.o_Instr,   m_instr);
      chk({tag, " Valid"},   {31'h0, bus.o_Valid}, {31'h0, m_valid});
`ifdef FETCH_PERF_CNT_EN
      chk({tag, " FetchCnt"},  fetch_cnt,  m_fcnt);
      chk({tag, " BubbleCnt"}, bubble_cnt, m_bcnt);
`endif
   endtask

   // Drive one cycle, advance the model by the rules, compare after the edge.
   task automatic step(input logic stall, input logic pcsrc, input logic [31:0] target,
                       input logic ready, input logic [31:0] rdata, input string tag);
      bus.i_stall        = stall;
      bus.i_PCSrc        = pcsrc;
      bus.i_BranchTarget = target;
      bus.i_imem_ready   = ready;
      bus.i_imem_rdata   = rdata;
      #1;
      chk({tag, " imem_addr"}, bus.o_imem_addr, m_pc);
      chk({tag, " imem_req"},  {31'h0, bus.o_imem_req}, 32'h1);
      @(posedge clk);
      #1;
      if (pcsrc) begin
         m_pc = target & ~32'h3;
         m_p4 = 0; m_instr = 0; m_valid = 0; m_bcnt++;
      end else if (stall) begin
         // everything holds
      end else if (!ready) begin
         m_p4 = 0; m_instr = 0; m_valid = 0; m_bcnt++;
      end else begin
         m_p4 = m_pc + 4; m_instr = rdata; m_valid = 1; m_pc = m_pc + 4; m_fcnt++;
      end
      check_model(tag);
   endtask

   function automatic vec_t mk(input logic st, input logic ps, input logic [31:0] tg,
                               input logic rd, input logic [31:0] dat,
                               input logic [31:0] epc, input logic [31:0] ep4,
                               input logic [31:0] ein, input logic ev);
      vec_t v;
      v.stall = st; v.pcsrc = ps; v.target = tg; v.ready = rd; v.rdata = dat;
      v.e_pc = epc; v.e_p4 = ep4; v.e_instr = ein; v.e_valid = ev;
      return v;
   endfunction

   initial begin
      n_tests = 0;
      n_fail  = 0;
      model_reset();

      vecs[0]  = mk(0, 0, 32'h0,         1, 32'h2001_0005, 32'h4,         32'h4,  32'h2001_0005, 1);
      vecs[1]  = mk(0, 0, 32'h0,         1, 32'h1111_1111, 32'h8,         32'h8,  32'h1111_1111, 1);
      vecs[2]  = mk(1, 0, 32'h0,         1, 32'hDEAD_0001, 32'h8,         32'h8,  32'h1111_1111, 1);
      vecs[3]  = mk(1, 0, 32'h0,         0, 32'hDEAD_0002, 32'h8,         32'h8,  32'h1111_1111, 1);
      vecs[4]  = mk(0, 0, 32'h0,         1, 32'h2222_2222, 32'hC,         32'hC,  32'h2222_2222, 1);
      vecs[5]  = mk(1, 1, 32'h43,        1, 32'hDEAD_0003, 32'h40,        32'h0,  32'h0,         0);
      vecs[6]  = mk(0, 1, 32'h12,        0, 32'hDEAD_0004, 32'h10,        32'h0,  32'h0,         0);
      vecs[7]  = mk(0, 0, 32'h0,         0, 32'hDEAD_0005, 32'h10,        32'h0,  32'h0,         0);
      vecs[8]  = mk(0, 0, 32'h0,         0, 32'hDEAD_0006, 32'h10,        32'h0,  32'h0,         0);
      vecs[9]  = mk(0, 0, 32'h0,         0, 32'hDEAD_0007, 32'h10,        32'h0,  32'h0,         0);
      vecs[10] = mk(0, 0, 32'h0,         1, 32'h3333_3333, 32'h14,        32'h14, 32'h3333_3333, 1);
      vecs[11] = mk(0, 1, 32'hFFFF_FFFF, 1, 32'hDEAD_0008, 32'hFFFF_FFFC, 32'h0,  32'h0,         0);
      vecs[12] = mk(0, 0, 32'h0,         1, 32'h4444_4444, 32'h0,         32'h0,  32'h4444_4444, 1);
      vecs[13] = mk(1, 0, 32'h0,         0, 32'hDEAD_0009, 32'h0,         32'h0,  32'h4444_4444, 1);

      bus.i_stall = 0; bus.i_PCSrc = 0; bus.i_BranchTarget = 0;
      bus.i_imem_ready = 1; bus.i_imem_rdata = 0;
      rstn = 1'b1;
      #1 rstn = 1'b0;
      #1;
      check_model("reset");
      chk("reset imem_req", {31'h0, bus.o_imem_req}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check_model("reset held");
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 14; i++) begin
         step(vecs[i].stall, vecs[i].pcsrc, vecs[i].target, vecs[i].ready, vecs[i].rdata,
              $sformatf("vec%0d", i));
         chk($sformatf("vec%0d tbl PC", i),      bus.o_PC,      vecs[i].e_pc);
         chk($sformatf("vec%0d tbl PCplus4", i), bus.o_PCplus4, vecs[i].e_p4);
         chk($sformatf("vec%0d tbl Instr", i),   bus.o_Instr,   vecs[i].e_instr);
         chk($sformatf("vec%0d tbl Valid", i),   {31'h0, bus.o_Valid}, {31'h0, vecs[i].e_valid});
      end

      // Build up non-zero state, then reset mid-cycle with no clock edge.
      step(0, 1, 32'h0000_1000, 1, 32'h0, "pre-rst redirect");
      step(0, 0, 32'h0, 1, 32'h5555_AAAA, "pre-rst fetch");
      #2 rstn = 1'b0;
      #1;
      model_reset();
      check_model("async reset");
      chk("async reset imem_req", {31'h0, bus.o_imem_req}, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      step(0, 0, 32'h0, 1, 32'h0BAD_F00D, "post-rst first fetch");

      for (int i = 0; i < 400; i++) begin
         logic        st, ps, rd;
         logic [31:0] tg, dat;
         st  = ($urandom_range(0, 3) == 0);
         ps  = ($urandom_range(0, 9) == 0);
         rd  = ($urandom_range(0, 3) != 0);
         tg  = (i % 50 == 7) ? 32'hFFFF_FFF9 : $urandom;
         dat = $urandom;
         step(st, ps, tg, rd, dat, $sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
